serial_adder: RTL

- Bit-serial unsigned adder, the sequential stage built directly around the team's half_adder block.
- Each bit slice is two half_adder instances plus an OR on their carries, reused every cycle.
- A carry flip-flop carries between bit positions.
- Operands are loaded in parallel on a start pulse and added LSB-first, one bit per clock. The result and carry-out are presented with a one-cycle done pulse.

---
 rtl/serial_adder_if.sv | 23 ++
 rtl/serial_adder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master drives requests; the slave (the adder) drives results.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             busy;
  logic             done;

  modport master (
    output start, a_in, b_in,
    input  sum, c_out, busy, done
  );

  modport slave (
    input  start, a_in, b_in,
    output sum, c_out, busy, done
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: operands are loaded on start and added LSB-first,
// one bit per clock, through a full-adder slice built from two half adders.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             ha0_s, ha0_c;
  logic             bit_s, ha1_c;
  logic             carry_next;

  half_adder u_ha0 (
    .a (a_sh_q[0]),
    .b (b_sh_q[0]),
    .s (ha0_s),
    .c (ha0_c)
  );

  half_adder u_ha1 (
    .a (ha0_s),
    .b (carry_q),
    .s (bit_s),
    .c (ha1_c)
  );

  assign carry_next = ha0_c | ha1_c;

  // The result register holds only WIDTH-1 bits: the final bit goes straight
  // into sum on the last ADD edge, so it never needs storing.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    busy_d  = busy_q;
    done_d  = done_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (bus.start) begin
          a_sh_d  = bus.a_in;
          b_sh_d  = bus.b_in;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = ADD;
          busy_d  = 1'b1;
        end
      end

      ADD: begin
        carry_d = carry_next;
        res_d   = (WIDTH-1)'({bit_s, res_q} >> 1);
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = {bit_s, res_q};
          c_out_d = carry_next;
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule
